// File: rtl/rw_arbiter.sv
// Two-requester round-robin front end for a shared R/W FSM. Latches the granted
// request, issues it, re-issues cancelled attempts up to MAX_RETRY times, then acks.
module rw_arbiter #(
   parameter int MAX_RETRY = 3
) (
   input  logic        clk,
   input  logic        rst_L,
   input  logic        req0,
   input  logic        read0,
   input  logic [15:0] addr0,
   input  logic [63:0] wdata0,
   input  logic        req1,
   input  logic        read1,
   input  logic [15:0] addr1,
   input  logic [63:0] wdata1,
   output logic        ack0,
   output logic        err0,
   output logic        ack1,
   output logic        err1,
   output logic [63:0] rdata,
   output logic        rw_tran_ready,
   output logic        rw_read,
   output logic [15:0] rw_addr,
   output logic [63:0] rw_data_down,
   input  logic        rw_done,
   input  logic        rw_cancel,
   input  logic        rw_recv_ready,
   input  logic [63:0] rw_data_up
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      BUSY  = 3'd2,
      GAP   = 3'd3,
      RESP  = 3'd4
   } state_t;

   localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

   state_t      r_state;
   state_t      w_state_next;
   logic        r_gnt;
   logic        r_last;
   logic        r_read;
   logic        r_err;
   logic [15:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_rdata;
   logic [2:0]  r_retry;

   logic        w_any_req;
   logic        w_gnt_sel;
   logic        w_can_retry;
   logic        w_drive;
   logic        w_resp;

   // On a tie the requester not granted last wins; r_last resets to 1 so req0 wins first.
   assign w_any_req   = req0 | req1;
   assign w_gnt_sel   = (req0 & req1) ? ~r_last : req1;
   assign w_can_retry = (r_retry < MAX_R);

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_drive       = 1'b0;
      w_resp        = 1'b0;
      rw_tran_ready = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_next = ISSUE;
            end
         end
         ISSUE: begin
            rw_tran_ready = 1'b1;
            w_drive       = 1'b1;
            w_state_next  = BUSY;
         end
         BUSY: begin
            w_drive = 1'b1;
            if (rw_done) begin
               w_state_next = (rw_cancel && w_can_retry) ? GAP : RESP;
            end
         end
         GAP: begin
            w_state_next = ISSUE;
         end
         RESP: begin
            w_resp       = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase

      rw_read      = w_drive ? r_read  : 1'b0;
      rw_addr      = w_drive ? r_addr  : 16'd0;
      rw_data_down = w_drive ? r_wdata : 64'd0;
      ack0         = w_resp & ~r_gnt;
      ack1         = w_resp &  r_gnt;
      err0         = w_resp & ~r_gnt & r_err;
      err1         = w_resp &  r_gnt & r_err;
      rdata        = w_resp ? r_rdata : 64'd0;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         r_gnt   <= 1'b0;
         r_last  <= 1'b1;
         r_read  <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= 16'd0;
         r_wdata <= 64'd0;
         r_rdata <= 64'd0;
         r_retry <= 3'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_gnt   <= w_gnt_sel;
                  r_last  <= w_gnt_sel;
                  r_read  <= w_gnt_sel ? read1  : read0;
                  r_addr  <= w_gnt_sel ? addr1  : addr0;
                  r_wdata <= w_gnt_sel ? wdata1 : wdata0;
                  r_rdata <= 64'd0;
                  r_retry <= 3'd0;
                  r_err   <= 1'b0;
               end
            end
            BUSY: begin
               // A cancelled attempt never leaves stale read data behind.
               if (rw_done && rw_cancel) begin
                  r_rdata <= 64'd0;
                  if (w_can_retry) begin
                     r_retry <= r_retry + 3'd1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end else if (rw_recv_ready && r_read) begin
                  r_rdata <= rw_data_up;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rw_arbiter.sv
// Randomised and directed bench for rw_arbiter; the bench plays both requesters
// and the downstream R/W FSM, and predicts outcomes from the arbitration/retry rules.
module tb_rw_arbiter;

   localparam int MAXR = 3;

   logic        clk = 1'b0;
   logic        rst_L = 1'b1;
   logic        req0 = 0, read0 = 0, req1 = 0, read1 = 0;
   logic [15:0] addr0 = 0, addr1 = 0;
   logic [63:0] wdata0 = 0, wdata1 = 0;
   logic        ack0, err0, ack1, err1;
   logic [63:0] rdata;
   logic        rw_tran_ready, rw_read;
   logic [15:0] rw_addr;
   logic [63:0] rw_data_down;
   logic        rw_done = 0, rw_cancel = 0, rw_recv_ready = 0;
   logic [63:0] rw_data_up = 0;

   int n_cmp = 0;
   int n_bad = 0;
   int m_last = 1;   // model: last-granted requester (1 => requester 0 wins a tie)

   typedef struct {
      int          first_wait;
      int          pulses;
      bit          timeout;
      bit          acked;
      int          who;
      logic        err;
      logic [63:0] rd;
      logic        cap_read;
      logic [15:0] cap_addr;
      logic [63:0] cap_data;
      int          proto_bad;
   } obs_t;

   rw_arbiter #(.MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst_L(rst_L),
      .req0(req0), .read0(read0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .read1(read1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .err0(err0), .ack1(ack1), .err1(err1), .rdata(rdata),
      .rw_tran_ready(rw_tran_ready), .rw_read(rw_read), .rw_addr(rw_addr),
      .rw_data_down(rw_data_down), .rw_done(rw_done), .rw_cancel(rw_cancel),
      .rw_recv_ready(rw_recv_ready), .rw_data_up(rw_data_up)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int exp_pulses(input int nc);
      return (nc > MAXR) ? MAXR + 1 : nc + 1;
   endfunction

   function automatic int exp_winner(input bit r0, input bit r1);
      if (r0 && r1) return (m_last == 1) ? 0 : 1;
      return r1 ? 1 : 0;
   endfunction

   // Downstream R/W FSM model: answers each issue after 'delay' cycles, cancelling
   // the first 'ncancel' attempts, and records what the arbiter did.
   task automatic serve(input int ncancel, input int delay, input logic [63:0] up, output obs_t o);
      int attempt;
      bit cancel;
      o.first_wait = 0; o.pulses = 0; o.timeout = 0; o.acked = 0; o.who = -1;
      o.err = 0; o.rd = '0; o.cap_read = 0; o.cap_addr = '0; o.cap_data = '0; o.proto_bad = 0;
      do begin
         @(negedge clk);
         o.first_wait++;
      end while (!rw_tran_ready && o.first_wait < 20);
      if (!rw_tran_ready) begin
         o.timeout = 1;
         return;
      end
      attempt = 0;
      while (!o.acked && !o.timeout) begin
         o.pulses++;
         if (attempt == 0) begin
            o.cap_read = rw_read; o.cap_addr = rw_addr; o.cap_data = rw_data_down;
         end else if ({rw_read, rw_addr, rw_data_down} !== {o.cap_read, o.cap_addr, o.cap_data}) begin
            o.proto_bad++;
         end
         cancel = (attempt < ncancel);
         for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            if (rw_tran_ready || ack0 || ack1 ||
                {rw_read, rw_addr, rw_data_down} !== {o.cap_read, o.cap_addr, o.cap_data})
               o.proto_bad++;
         end
         rw_done = 1; rw_cancel = cancel; rw_recv_ready = o.cap_read;
         rw_data_up = cancel ? {$urandom, $urandom} : up;
         @(negedge clk);
         rw_done = 0; rw_cancel = 0; rw_recv_ready = 0; rw_data_up = '0;
         if (ack0 && ack1) o.proto_bad++;
         if (ack0 || ack1) begin
            o.acked = 1; o.who = ack1 ? 1 : 0; o.err = ack1 ? err1 : err0; o.rd = rdata;
            if (ack1) req1 = 0; else req0 = 0;
            @(negedge clk);
            if (ack0 || ack1) o.proto_bad++;
         end else begin
            if (rw_tran_ready || rw_read || rw_addr != 0 || rw_data_down != 0) o.proto_bad++;
            @(negedge clk);
            attempt++;
            if (!rw_tran_ready || attempt > 12) o.timeout = 1;
         end
      end
      $display("txn who=%0d read=%0d addr=%h pulses=%0d err=%0d rdata=%h",
               o.who, o.cap_read, o.cap_addr, o.pulses, o.err, o.rd);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_L = 0; req0 = 0; req1 = 0;
      rw_done = 0; rw_cancel = 0; rw_recv_ready = 0; rw_data_up = '0;
      repeat (2) @(negedge clk);
      rst_L = 1;
      m_last = 1;
   endtask

   task automatic test_reset();
      #1 rst_L = 0;
      req0 = 1; req1 = 1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({rw_tran_ready, rw_read, rw_addr, rw_data_down, ack0, ack1, err0, err1, rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got tr=%b ack=%b%b addr=%h rdata=%h want all 0",
                  rw_tran_ready, ack0, ack1, rw_addr, rdata);
      end
      req0 = 0; req1 = 0;
      rst_L = 1;
      m_last = 1;
      $display("txn reset released");
   endtask

   task automatic test_read();
      obs_t o;
      read0 = 1; addr0 = 16'h1234; wdata0 = 64'h0; req0 = 1;
      serve(0, 5, 64'hDEAD_BEEF_0000_0001, o);
      m_last = 0;
      n_cmp++; if (o.first_wait !== 1) begin n_bad++; $display("FAIL read_latency: got %0d want 1", o.first_wait); end
      n_cmp++; if (o.cap_read !== 1'b1 || o.cap_addr !== 16'h1234) begin n_bad++; $display("FAIL read_issue: got rd=%b addr=%h want rd=1 addr=1234", o.cap_read, o.cap_addr); end
      n_cmp++; if (o.proto_bad !== 0 || o.pulses !== 1) begin n_bad++; $display("FAIL read_protocol: got bad=%0d pulses=%0d want 0/1", o.proto_bad, o.pulses); end
      n_cmp++; if (o.who !== 0 || o.err !== 1'b0) begin n_bad++; $display("FAIL read_ack: got who=%0d err=%b want 0/0", o.who, o.err); end
      n_cmp++; if (o.rd !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL read_rdata: got %h want deadbeef00000001", o.rd); end
   endtask

   task automatic test_write();
      obs_t o;
      read1 = 0; addr1 = 16'h00F0; wdata1 = 64'hA5A5; req1 = 1;
      serve(0, 3, 64'h0, o);
      m_last = 1;
      n_cmp++; if (o.cap_read !== 1'b0 || o.cap_addr !== 16'h00F0 || o.cap_data !== 64'hA5A5) begin n_bad++; $display("FAIL write_issue: got rd=%b addr=%h data=%h want 0/00f0/a5a5", o.cap_read, o.cap_addr, o.cap_data); end
      n_cmp++; if (o.proto_bad !== 0) begin n_bad++; $display("FAIL write_protocol: got %0d violations want 0", o.proto_bad); end
      n_cmp++; if (o.who !== 1 || o.err !== 1'b0 || o.rd !== 64'h0) begin n_bad++; $display("FAIL write_ack: got who=%0d err=%b rdata=%h want 1/0/0", o.who, o.err, o.rd); end
   endtask

   task automatic test_tie();
      obs_t o;
      int want [4] = '{0, 1, 0, 1};
      apply_reset();
      read0 = 0; addr0 = 16'h0A00; wdata0 = 64'h11;
      read1 = 0; addr1 = 16'h0B00; wdata1 = 64'h22;
      for (int t = 0; t < 4; t++) begin
         if (t == 0 || t == 2) begin req0 = 1; req1 = 1; end
         serve(0, 1, 64'h0, o);
         n_cmp++; if (o.who !== want[t]) begin n_bad++; $display("FAIL tie_order[%0d]: got who=%0d want %0d", t, o.who, want[t]); end
         n_cmp++; if (o.first_wait !== 1 || o.proto_bad !== 0) begin n_bad++; $display("FAIL tie_b2b[%0d]: got wait=%0d bad=%0d want 1/0", t, o.first_wait, o.proto_bad); end
         n_cmp++; if (o.cap_addr !== (want[t] == 1 ? 16'h0B00 : 16'h0A00)) begin n_bad++; $display("FAIL tie_addr[%0d]: got %h", t, o.cap_addr); end
      end
      m_last = 1;
   endtask

   task automatic test_retry();
      obs_t o;
      read0 = 1; addr0 = 16'h4242; req0 = 1;
      serve(2, 2, 64'h0123_4567_89AB_CDEF, o);
      m_last = 0;
      n_cmp++; if (o.pulses !== 3 || o.timeout) begin n_bad++; $display("FAIL retry_pulses: got %0d (timeout=%0d) want 3", o.pulses, o.timeout); end
      n_cmp++; if (o.proto_bad !== 0) begin n_bad++; $display("FAIL retry_gap: got %0d violations want 0", o.proto_bad); end
      n_cmp++; if (o.who !== 0 || o.err !== 1'b0 || o.rd !== 64'h0123_4567_89AB_CDEF) begin n_bad++; $display("FAIL retry_ack: got who=%0d err=%b rdata=%h want 0/0/0123456789abcdef", o.who, o.err, o.rd); end
   endtask

   task automatic test_retry_exhausted();
      obs_t o;
      read0 = 1; addr0 = 16'h7777; req0 = 1;
      serve(4, 1, 64'hFFFF_0000_FFFF_0000, o);
      m_last = 0;
      n_cmp++; if (o.pulses !== 4) begin n_bad++; $display("FAIL exhaust_pulses: got %0d want 4", o.pulses); end
      n_cmp++; if (o.who !== 0 || o.err !== 1'b1) begin n_bad++; $display("FAIL exhaust_err: got who=%0d err=%b want 0/1", o.who, o.err); end
      n_cmp++; if (o.rd !== 64'h0 || o.proto_bad !== 0) begin n_bad++; $display("FAIL exhaust_rdata: got %h bad=%0d want 0/0", o.rd, o.proto_bad); end
   endtask

   task automatic test_reset_busy();
      obs_t o;
      int w = 0;
      @(negedge clk);
      read0 = 1; addr0 = 16'h0BAD; req0 = 1;
      do begin @(negedge clk); w++; end while (!rw_tran_ready && w < 20);
      n_cmp++; if (rw_tran_ready !== 1'b1) begin n_bad++; $display("FAIL rstbusy_issue: got tr=%b want 1", rw_tran_ready); end
      repeat (2) @(negedge clk);
      rst_L = 0; req0 = 0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({rw_tran_ready, rw_read, rw_addr, rw_data_down, ack0, ack1, err0, err1, rdata} !== '0) begin
            n_bad++; $display("FAIL rstbusy_outputs[%0d]: got tr=%b rd=%b addr=%h ack=%b%b want all 0", c, rw_tran_ready, rw_read, rw_addr, ack0, ack1);
         end
      end
      rst_L = 1;
      m_last = 1;
      @(negedge clk);
      n_cmp++; if (ack0 || ack1 || rw_tran_ready) begin n_bad++; $display("FAIL rstbusy_noack: got ack=%b%b tr=%b want 0", ack0, ack1, rw_tran_ready); end
      read1 = 0; addr1 = 16'h5150; wdata1 = 64'hCAFE; req1 = 1;
      serve(0, 2, 64'h0, o);
      m_last = 1;
      n_cmp++; if (o.who !== 1 || o.err !== 1'b0 || o.rd !== 64'h0) begin n_bad++; $display("FAIL rstbusy_req1: got who=%0d err=%b rdata=%h want 1/0/0", o.who, o.err, o.rd); end
      n_cmp++; if (o.cap_addr !== 16'h5150 || o.cap_data !== 64'hCAFE || o.first_wait !== 1) begin n_bad++; $display("FAIL rstbusy_issue2: got addr=%h data=%h wait=%0d want 5150/cafe/1", o.cap_addr, o.cap_data, o.first_wait); end
   endtask

   task automatic test_random();
      obs_t o;
      bit pend [2];
      int p, ngr, nc, dl, want;
      logic [63:0] up, e_rd;
      logic        e_read;
      logic [15:0] e_addr;
      logic [63:0] e_data;
      for (int it = 0; it < 25; it++) begin
         rw_done = 1; rw_cancel = 1'($urandom);
         @(negedge clk);
         rw_done = 0; rw_cancel = 0;
         n_cmp++;
         if ({rw_tran_ready, ack0, ack1, rw_read, rw_addr, rw_data_down} !== '0) begin
            n_bad++; $display("FAIL rand_stray_done[%0d]: got tr=%b ack=%b%b addr=%h want 0", it, rw_tran_ready, ack0, ack1, rw_addr);
         end
         p = $urandom_range(0, 2);
         pend[0] = (p != 1); pend[1] = (p != 0);
         read0 = 1'($urandom); addr0 = 16'($urandom); wdata0 = {$urandom, $urandom};
         read1 = 1'($urandom); addr1 = 16'($urandom); wdata1 = {$urandom, $urandom};
         req0 = pend[0]; req1 = pend[1];
         ngr = (p == 2) ? 2 : 1;
         for (int g = 0; g < ngr; g++) begin
            want = exp_winner(pend[0], pend[1]);
            nc = $urandom_range(0, 5); dl = $urandom_range(1, 4); up = {$urandom, $urandom};
            e_read = (want == 1) ? read1 : read0;
            e_addr = (want == 1) ? addr1 : addr0;
            e_data = (want == 1) ? wdata1 : wdata0;
            e_rd   = (nc <= MAXR && e_read) ? up : 64'h0;
            serve(nc, dl, up, o);
            pend[want] = 0;
            m_last = want;
            n_cmp++; if (o.who !== want || o.timeout) begin n_bad++; $display("FAIL rand_grant[%0d.%0d]: got who=%0d timeout=%0d want %0d", it, g, o.who, o.timeout, want); end
            n_cmp++; if ({o.cap_read, o.cap_addr, o.cap_data} !== {e_read, e_addr, e_data}) begin n_bad++; $display("FAIL rand_fields[%0d.%0d]: got %b/%h/%h want %b/%h/%h", it, g, o.cap_read, o.cap_addr, o.cap_data, e_read, e_addr, e_data); end
            n_cmp++; if (o.pulses !== exp_pulses(nc) || o.err !== 1'(nc > MAXR)) begin n_bad++; $display("FAIL rand_retry[%0d.%0d]: got pulses=%0d err=%b want %0d/%0d", it, g, o.pulses, o.err, exp_pulses(nc), nc > MAXR); end
            n_cmp++; if (o.rd !== e_rd) begin n_bad++; $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", it, g, o.rd, e_rd); end
            n_cmp++; if (o.proto_bad !== 0 || o.first_wait !== 1) begin n_bad++; $display("FAIL rand_protocol[%0d.%0d]: got bad=%0d wait=%0d want 0/1", it, g, o.proto_bad, o.first_wait); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_tie();
      test_retry();
      test_retry_exhausted();
      test_reset_busy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
